stopwatch_timer: RTL

Count-up stopwatch: the counting-direction counterpart of the countdown timer. Accumulates elapsed time in packed-BCD hours/minutes/seconds on a 1 Hz tick enable. Supports start/stop, clear, and lap (freeze display while counting continues). Drives the same display path and the same BCD field format as the countdown timer, so the display mux treats both blocks identically.

---
 rtl/stopwatch_timer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/stopwatch_timer.sv
// stopwatch_timer: count-up stopwatch with packed-BCD HH:MM:SS, start/stop,
// clear and lap freeze. Saturates at HOUR_MAX:59:59 and raises overflow.
// Display fields use the same BCD layout as the countdown timer.
module stopwatch_timer #(
  parameter logic [7:0] HOUR_MAX = 8'h99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [7:0] hour_out,
  output logic [7:0] minute_out,
  output logic [7:0] second_out,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] hours, minutes, seconds;
  logic [7:0] lap_hours, lap_minutes, lap_seconds;
  logic [7:0] hours_inc, minutes_inc, seconds_inc;
  logic       sec_wrap, min_wrap, at_max, count_en;

  // Add one to a packed-BCD byte; the caller handles wrap at 59.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Next live count for a one-second tick, rippling carries digit by digit.
  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    sec_wrap    = (seconds == 8'h59);
    min_wrap    = (minutes == 8'h59);
    at_max      = (hours == HOUR_MAX) && sec_wrap && min_wrap;
    count_en    = (state == RUN) && tick_1hz;
    seconds_inc = sec_wrap ? 8'h00 : bcd_inc(seconds);
    minutes_inc = minutes;
    hours_inc   = hours;
    if (sec_wrap) begin
      minutes_inc = min_wrap ? 8'h00 : bcd_inc(minutes);
      if (min_wrap) hours_inc = bcd_inc(hours);
    end
  end

  // Control FSM, live counter, lap register and registered display outputs.
  // NOTE: state is written with non-blocking assignments so every decision in
  // this block sees the values registered at the start of the cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hours       <= 8'h00;
      minutes     <= 8'h00;
      seconds     <= 8'h00;
      lap_hours   <= 8'h00;
      lap_minutes <= 8'h00;
      lap_seconds <= 8'h00;
      hour_out    <= 8'h00;
      minute_out  <= 8'h00;
      second_out  <= 8'h00;
      running     <= 1'b0;
      lap_active  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // Display trails the counter/lap registers by one cycle.
      hour_out   <= lap_active ? lap_hours   : hours;
      minute_out <= lap_active ? lap_minutes : minutes;
      second_out <= lap_active ? lap_seconds : seconds;

      if (clear) begin
        state       <= IDLE;
        hours       <= 8'h00;
        minutes     <= 8'h00;
        seconds     <= 8'h00;
        lap_hours   <= 8'h00;
        lap_minutes <= 8'h00;
        lap_seconds <= 8'h00;
        running     <= 1'b0;
        lap_active  <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        if (count_en) begin
          if (at_max) begin
            // Saturate: hold the count and park in PAUSE until cleared.
            overflow <= 1'b1;
            state    <= PAUSE;
            running  <= 1'b0;
          end else begin
            hours   <= hours_inc;
            minutes <= minutes_inc;
            seconds <= seconds_inc;
          end
        end

        if (start_stop && !overflow) begin
          if (state == RUN) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        // Lap capture takes the pre-increment count when a tick coincides.
        if (lap) begin
          if (state == RUN) begin
            if (!lap_active) begin
              lap_hours   <= hours;
              lap_minutes <= minutes;
              lap_seconds <= seconds;
              lap_active  <= 1'b1;
            end else begin
              lap_active <= 1'b0;
            end
          end else if (state == PAUSE && lap_active) begin
            lap_active <= 1'b0;
          end
        end
      end
    end
  end

endmodule
